// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shift/rotate engine for the ALU datapath.
// Moves up to STEP bit positions per clock. The ALU control FSM captures
// `result` into ZLO when `done` pulses.
//
// Handshake: `start` is sampled only in IDLE. A rising edge with start=1 in
// IDLE is the accept: operands are captured and the unit is busy until the
// one-cycle `done` pulse. `start` while busy or in DONE is dropped, not queued.
//
// Ports:
//   clk      in   rising-edge clock
//   clr      in   asynchronous active-low reset
//   start    in   launch request (IDLE only)
//   mode     in   000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, others illegal
//   data_in  in   operand, captured on accept
//   amount   in   shift count, captured on accept
//   busy     out  high while shifting
//   done     out  one-cycle pulse, result valid
//   illegal  out  pulses with done when the captured mode was illegal
//   result   out  working register; holds the final value after done
module seq_shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] result
);

  // One extra bit so STEP itself (which may equal WIDTH) is representable.
  localparam int CNT_W = AMT_W + 1;
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       mode_q, mode_d;
  logic             ill_q, ill_d;

  logic [CNT_W-1:0] rem_ext;
  logic [CNT_W-1:0] n;
  logic [WIDTH-1:0] step_res;

  // Apply operation m by a fixed distance k (0..STEP). Rotates by k=WIDTH
  // wrap back to the identity because the complementary shift is by zero.
  function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] v,
                                                input logic [2:0] m,
                                                input int k);
    case (m)
      3'b000:  return v >> k;
      3'b001:  return $unsigned($signed(v) >>> k);
      3'b010:  return v << k;
      3'b011:  return (v >> k) | (v << (WIDTH - k));
      3'b100:  return (v << k) | (v >> (WIDTH - k));
      default: return v;
    endcase
  endfunction

  always_comb begin
    rem_ext = {1'b0, rem_q};
    n       = (rem_ext < STEP_C) ? rem_ext : STEP_C;

    // Barrel over the STEP+1 possible per-cycle distances.
    step_res = result_q;
    for (int k = 0; k <= STEP; k++) begin
      if (n == CNT_W'(k)) step_res = apply_op(result_q, mode_q, k);
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    ill_d    = ill_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SHIFT;
          result_d = data_in;
          mode_d   = mode;
          ill_d    = (mode > 3'd4);
          // An illegal op spends its single SHIFT cycle doing nothing.
          rem_d    = (mode > 3'd4) ? '0 : amount;
        end
      end
      S_SHIFT: begin
        result_d = step_res;
        // n never exceeds rem_q, so it fits in AMT_W bits here.
        rem_d    = rem_q - n[AMT_W-1:0];
        if (rem_ext <= STEP_C) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      rem_q    <= '0;
      mode_q   <= 3'b000;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      ill_q    <= ill_d;
    end
  end

  assign busy    = (state_q == S_SHIFT);
  assign done    = (state_q == S_DONE);
  assign illegal = (state_q == S_DONE) && ill_q;
  assign result  = result_q;

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Multi-cycle, parametrised shift/rotate engine for the CPU datapath ALU path.
- Supersedes the single-mode combinational shift-right-arithmetic op and adds SHR, SHRA, SHL, ROR and ROL.
- Shifts STEP bits per clock under a start/busy/done handshake; the ALU control FSM launches it and captures the result into ZLO.

Parameters:
- WIDTH, 32: operand/result width; power of two, >= 4.
- STEP, 1: maximum bits shifted per clock; 1 <= STEP <= WIDTH.
- AMT_W, $clog2(WIDTH): localparam; shift-amount width.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  reset; asynchronous, active-low.
- start  in  1  launch request; sampled only in IDLE.
- mode  in  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; 101-111 illegal.
- data_in  in  WIDTH  operand; captured on accept.
- amount  in  AMT_W  shift count; captured on accept; a value of WIDTH or more is not representable.
- busy  out  1  high in SHIFT state.
- done  out  1  one-cycle pulse, result valid.
- illegal  out  1  pulses with done when the captured mode was illegal.
- result  out  WIDTH  working register.

Behaviour:
- Reset (clr=0, async) forces:
  - state=IDLE
  - result=0, busy=0, done=0, illegal=0
  - internal remaining count=0, captured mode=000
- Reset mid-operation aborts immediately: no done pulse, result cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at a rising edge is an accept.
  - On accept: result<=data_in, remaining<=amount, mode captured, state<=SHIFT.
  - With an illegal mode, remaining<=0 and an illegal flag is latched.
- SHIFT, busy=1, each edge:
  - Let n = min(remaining, STEP).
  - Apply n-bit op to result; remaining<=remaining-n.
  - If remaining <= STEP (including 0), state<=DONE; else stay in SHIFT.
- DONE:
  - done=1 for exactly one cycle; illegal=1 in the same cycle if flagged.
  - Next edge returns to IDLE.
- Ops on result:
  - SHR: zero fill from MSB.
  - SHRA: fill with result[WIDTH-1], sign preserved every step.
  - SHL: zero fill from LSB.
  - ROR/ROL: bits wrap modulo WIDTH.
  - Illegal mode: result unchanged (= data_in).
- Latency: done is high in cycle max(1, ceil(amount/STEP)) + 1 counted from the accept edge. Equivalently, done rises after edge number max(1, ceil(amount/STEP)) following accept.
- amount=0: one SHIFT cycle with no change; result=data_in at done.
- start while busy or in DONE is ignored. It is neither queued nor able to alter operands; a new accept is possible only from IDLE.
- data_in, amount and mode may change freely after accept without effect.
- result holds its final value after done until the next accept or reset.
- Intermediate result values during SHIFT are visible but not guaranteed meaningful.
- Single always_ff for state/regs plus a combinational step function. The step function is an n-bit barrel over 0..STEP, STEP+1 entries.

Test Plan:
- WIDTH=32, STEP=1: SHRA, data_in=0x80000000, amount=4.
  - Expect busy high 4 cycles, done pulse, result=0xF8000000.
  - Repeat with mode SHR: result=0x08000000.
- WIDTH=32, STEP=1: SHRA, data_in=0xFFFFFFFF, amount=10.
  - Expect result=0xFFFFFFFF, done 10 edges after accept.
  - ROL 0x80000001 by 1 -> 0x00000003.
  - ROR 0x00000001 by 31 -> 0x00000002.
- WIDTH=32, STEP=4: SHL, data_in=0x0000000A, amount=10.
  - Expect 3 SHIFT cycles (4,4,2), result=0x00002800, exactly one done pulse.
- amount=0 with any legal mode, data_in=0x12345678: done after 1 edge, result=0x12345678.
  - Mode=101: illegal and done pulse together, result=data_in.
- Accept SHR 0xF0000000 by 8 (STEP=1); on cycle 3 pulse start with new data_in=0x1.
  - Expect new start ignored, result=0x00F00000, single done.
- Launch SHRA by 20; drive clr=0 asynchronously mid-SHIFT (between edges).
  - Expect busy/result to clear immediately with no done.
  - After release, a fresh accept completes normally.
